uart_tx_feeder: RTL and testbench

Byte FIFO and frame sequencer sitting directly upstream of the UART transmitter. Accepts bytes from a host-side write port, buffers them, and issues one transmitter frame per byte by driving the transmitter's data and control inputs. Observes the transmitter's ready/done handshake, so back-to-back frames leave the line without host involvement. Latches frame format (parity enable, parity sense, stop bits) per frame.

---
 rtl/uart_tx_feeder.sv | 209 ++++++++++++++++++++
 tb/tb_uart_tx_feeder.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus frame sequencer feeding a UART transmitter.
// Bytes pushed on the write port are buffered and launched one frame at a
// time. The transmitter's ready/done handshake paces the frames, so
// back-to-back frames go out without host involvement.
module uart_tx_feeder #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  ovf,
  input  logic                  ovf_clr,
  input  logic                  cfg_par_en,
  input  logic                  cfg_par_odd,
  input  logic                  cfg_two_stop,
  output logic [7:0]            tx_data_o,
  output logic [3:0]            tx_ctrl_o,
  input  logic                  tx_ready_i,
  input  logic                  tx_done_i,
  output logic                  busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } state_e;

  // Storage is never reset; only the pointers define what is valid.
  logic [7:0]    mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [2:0]    tx_fmt_q, tx_fmt_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  state_e        state_q, state_d;

  logic          push_s;
  logic          launch_s;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: one frame per byte, paced by the transmitter handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty_q && tx_ready_i) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // Transmitter dropping ready means it has latched the byte.
        if (!tx_ready_i) begin
          state_d = ST_WAIT_DONE;
        end else begin
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_DONE: begin
        if (tx_done_i) begin
          state_d = ST_GAP;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_GAP: begin
        // Wait until the transmitter is fully back in idle before relaunching.
        if (!tx_done_i && tx_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GAP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs, computed from the next state so they are registered.
  always_comb begin
    start_d = 1'b0;
    busy_d  = 1'b0;
    if (state_d == ST_START) begin
      start_d = 1'b1;
    end else begin
      start_d = 1'b0;
    end
    if (state_d != ST_IDLE) begin
      busy_d = 1'b1;
    end else begin
      busy_d = 1'b0;
    end
  end

  // FIFO pointers, flags, overflow and per-frame latched byte/format.
  always_comb begin
    push_s    = wr_en && !full_q;
    launch_s  = (state_q == ST_IDLE) && (state_d == ST_START);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ovf_d     = ovf_q;
    tx_data_d = tx_data_q;
    tx_fmt_d  = tx_fmt_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    // The launch edge pops the head byte and snapshots the frame format.
    if (launch_s) begin
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
      tx_data_d = mem[rd_ptr_q[PW-2:0]];
      tx_fmt_d  = {cfg_par_en, cfg_par_odd, cfg_two_stop};
    end else begin
      rd_ptr_d  = rd_ptr_q;
      tx_data_d = tx_data_q;
      tx_fmt_d  = tx_fmt_q;
    end

    // A dropped write beats a same-cycle clear.
    if (wr_en && full_q) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    level_d = wr_ptr_d - rd_ptr_d;
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
              (wr_ptr_d[PW-2:0] == rd_ptr_d[PW-2:0]);
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      tx_data_q <= 8'h00;
      tx_fmt_q  <= 3'b000;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      ovf_q     <= ovf_d;
      tx_data_q <= tx_data_d;
      tx_fmt_q  <= tx_fmt_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
    end
  end

  // FIFO storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem[wr_ptr_q[PW-2:0]] <= wr_data;
    end
  end

  assign full      = full_q;
  assign empty     = empty_q;
  assign level     = level_q;
  assign ovf       = ovf_q;
  assign tx_data_o = tx_data_q;
  assign tx_ctrl_o = {tx_fmt_q, start_q};
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Testbench for uart_tx_feeder: a behavioural transmitter and a serial
// reference receiver, with a queue of expected {format, byte} frames.
module tb_uart_tx_feeder;

  localparam int BIT_CLKS = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, empty, ovf, busy;
  logic [4:0] level;
  logic       ovf_clr;
  logic       cfg_par_en, cfg_par_odd, cfg_two_stop;
  logic [7:0] tx_data_o;
  logic [3:0] tx_ctrl_o;
  logic       tx_ready_i, tx_done_i;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_feeder #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .ovf(ovf), .ovf_clr(ovf_clr),
    .cfg_par_en(cfg_par_en), .cfg_par_odd(cfg_par_odd), .cfg_two_stop(cfg_two_stop),
    .tx_data_o(tx_data_o), .tx_ctrl_o(tx_ctrl_o),
    .tx_ready_i(tx_ready_i), .tx_done_i(tx_done_i), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- frame format helpers ----------------
  function automatic logic [15:0] build_frame(input logic [7:0] d, input logic [2:0] f);
    logic [15:0] b;
    b      = 16'hFFFF;
    b[0]   = 1'b0;
    b[8:1] = d;
    if (f[2]) b[9] = (^d) ^ f[1];
    return b;
  endfunction

  function automatic int frame_len(input logic [2:0] f);
    return 10 + int'(f[2]) + int'(f[0]);
  endfunction

  // ---------------- behavioural transmitter ----------------
  logic        m_ready, m_done, txd, tx_hold;
  int          m_phase, m_cnt, m_n;
  logic [3:0]  m_idx;
  logic [15:0] m_bits;

  assign tx_ready_i = m_ready & ~tx_hold;
  assign tx_done_i  = m_done;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0; m_ready <= 1'b1; m_done <= 1'b0; txd <= 1'b1;
      m_cnt <= 0; m_idx <= 4'd0; m_n <= 10; m_bits <= 16'hFFFF;
    end else begin
      case (m_phase)
        0: if (tx_ctrl_o[0]) m_phase <= 1;
        1: begin
          m_bits  <= build_frame(tx_data_o, tx_ctrl_o[3:1]);
          m_n     <= frame_len(tx_ctrl_o[3:1]);
          m_ready <= 1'b0;
          txd     <= 1'b0;
          m_idx   <= 4'd0;
          m_cnt   <= 0;
          m_phase <= 2;
        end
        2: begin
          if (m_cnt == BIT_CLKS - 1) begin
            m_cnt <= 0;
            if (32'(m_idx) == m_n - 1) begin
              txd <= 1'b1; m_done <= 1'b1; m_phase <= 3;
            end else begin
              m_idx <= m_idx + 4'd1;
              txd   <= m_bits[m_idx + 4'd1];
            end
          end else begin
            m_cnt <= m_cnt + 1;
          end
        end
        3: begin m_done <= 1'b0; m_phase <= 4; end
        4: m_phase <= 5;
        5: begin m_ready <= 1'b1; m_phase <= 0; end
        default: m_phase <= 0;
      endcase
    end
  end

  // ---------------- reference receiver and expected queue ----------------
  typedef struct packed { logic [2:0] fmt; logic [7:0] data; } exp_t;
  exp_t exp_q[$];
  int   exp_total = 0;
  int   rx_frames = 0;
  logic rx_busy = 1'b0;

  initial begin
    int          rx_cnt;
    int          rx_n;
    exp_t        rx_exp;
    logic [15:0] rx_sh;
    logic [3:0]  bidx;
    rx_cnt = 0; rx_n = 10; rx_exp = '0; rx_sh = 16'hFFFF;
    forever begin
      @(negedge clk);
      if (rst) begin
        rx_busy = 1'b0;
      end else if (!rx_busy) begin
        if (txd === 1'b0) begin
          rx_busy = 1'b1;
          rx_cnt  = 0;
          rx_sh   = 16'hFFFF;
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
            rx_exp = '0;
          end else begin
            rx_exp = exp_q.pop_front();
          end
          rx_n = frame_len(rx_exp.fmt);
        end
      end else begin
        rx_cnt++;
        if (rx_cnt % BIT_CLKS == BIT_CLKS / 2) begin
          bidx = 4'(rx_cnt / BIT_CLKS);
          rx_sh[bidx] = txd;
        end
        if (rx_cnt == (rx_n - 1) * BIT_CLKS + BIT_CLKS / 2) begin
          rx_busy = 1'b0;
          rx_frames++;
          check("rx_start_bit", 32'(rx_sh[0]), 32'd0);
          check("rx_data", 32'(rx_sh[8:1]), 32'(rx_exp.data));
          if (rx_exp.fmt[2]) begin
            check("rx_parity", 32'(rx_sh[9]), 32'((^rx_exp.data) ^ rx_exp.fmt[1]));
            check("rx_stop", 32'(rx_sh[10]), 32'd1);
          end else begin
            check("rx_stop", 32'(rx_sh[9]), 32'd1);
          end
          if (rx_exp.fmt[0]) check("rx_stop2", 32'(rx_sh[rx_n - 1]), 32'd1);
        end
      end
    end
  end

  // ---------------- protocol monitor ----------------
  int         n_starts = 0, bad_start = 0, max_run = 0, unstable = 0;
  logic [7:0] cap_data = 8'h00;
  logic [2:0] cap_fmt  = 3'b000;

  initial begin
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      if (tx_ctrl_o[0] === 1'b1) begin
        if (run == 0) n_starts++;
        run++;
        if (run > max_run) max_run = run;
        if (tx_ready_i !== 1'b1) bad_start++;
        cap_data = tx_data_o;
        cap_fmt  = tx_ctrl_o[3:1];
      end else begin
        run = 0;
        if (busy === 1'b1 && (tx_data_o !== cap_data || tx_ctrl_o[3:1] !== cap_fmt)) unstable++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input logic [2:0] f, input logic [7:0] d);
    exp_q.push_back({f, d});
    exp_total++;
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(busy == 1'b0 && empty == 1'b1 && exp_q.size() == 0 && !rx_busy) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_tx_latched(input int budget);
    int n;
    n = 0;
    while (tx_ready_i !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check("wait_latch_timeout", 32'd1, 32'd0);
  endtask

  task automatic set_cfg(input logic [2:0] f);
    {cfg_par_en, cfg_par_odd, cfg_two_stop} = f;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_full"},  32'(full),      32'd0);
    check({tag, "_empty"}, 32'(empty),     32'd1);
    check({tag, "_level"}, 32'(level),     32'd0);
    check({tag, "_ovf"},   32'(ovf),       32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_data"},  32'(tx_data_o), 32'd0);
    check({tag, "_ctrl"},  32'(tx_ctrl_o), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] b;
    logic [2:0] f;
    int         s0;
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; ovf_clr = 1'b0; tx_hold = 1'b0;
    set_cfg(3'b000);
    tick(); tick();
    rst = 1'b0;
    check_reset_values("reset");

    // Single byte: start two cycles after the write, one cycle wide.
    expect_frame(3'b000, 8'hA5);
    write_byte(8'hA5);
    check("single_empty_after_wr", 32'(empty), 32'd0);
    check("single_no_start_yet", 32'(tx_ctrl_o[0]), 32'd0);
    tick();
    check("single_start", 32'(tx_ctrl_o), 32'h1);
    check("single_data", 32'(tx_data_o), 32'hA5);
    check("single_empty_after_pop", 32'(empty), 32'd1);
    check("single_busy", 32'(busy), 32'd1);
    tick();
    check("single_start_low", 32'(tx_ctrl_o[0]), 32'd0);
    wait_idle(300);
    check("single_busy_after", 32'(busy), 32'd0);
    check("single_data_held", 32'(tx_data_o), 32'hA5);

    // Burst of 20 while the transmitter is held off.
    tx_hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; wr_data = 8'(i); ovf_clr = (i == 18);
      tick();
      if (i == 15) begin
        check("burst_full16", 32'(full), 32'd1);
        check("burst_level16", 32'(level), 32'd16);
        check("burst_no_ovf_yet", 32'(ovf), 32'd0);
      end
      if (i == 16) check("burst_ovf17", 32'(ovf), 32'd1);
      if (i == 18) check("ovf_set_beats_clr", 32'(ovf), 32'd1);
    end
    wr_en = 1'b0; ovf_clr = 1'b0;
    check("burst_level_end", 32'(level), 32'd16);
    for (int i = 0; i < 16; i++) expect_frame(3'b000, 8'(i));
    tx_hold = 1'b0;
    wait_idle(3000);
    check("burst_ovf_sticky", 32'(ovf), 32'd1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("burst_ovf_cleared", 32'(ovf), 32'd0);

    // Format latching across a mid-frame cfg change.
    set_cfg(3'b110);
    expect_frame(3'b110, 8'h3C);
    write_byte(8'h3C);
    wait_tx_latched(20);
    tick(); tick(); tick();
    set_cfg(3'b000);
    check("fmt_latched", 32'(tx_ctrl_o[3:1]), 32'h6);
    wait_idle(300);
    expect_frame(3'b000, 8'h5A);
    write_byte(8'h5A);
    tick();
    check("fmt_next_frame", 32'(tx_ctrl_o), 32'h1);
    wait_idle(300);

    // Write on the launch edge with the FIFO full: write dropped.
    tx_hold = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      expect_frame(3'b000, b);
      write_byte(b);
    end
    check("pp_full", 32'(full), 32'd1);
    tx_hold = 1'b0; wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    check("pp_full_launch", 32'(tx_ctrl_o[0]), 32'd1);
    check("pp_full_level", 32'(level), 32'd15);
    check("pp_full_ovf", 32'(ovf), 32'd1);
    wait_idle(3000);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;

    // Write on the launch edge with level 5: level unchanged.
    tx_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      expect_frame(3'b000, b);
      write_byte(b);
    end
    check("pp5_level_before", 32'(level), 32'd5);
    b = 8'($urandom);
    expect_frame(3'b000, b);
    tx_hold = 1'b0; wr_en = 1'b1; wr_data = b;
    tick();
    wr_en = 1'b0;
    check("pp5_launch", 32'(tx_ctrl_o[0]), 32'd1);
    check("pp5_level", 32'(level), 32'd5);
    check("pp5_ovf", 32'(ovf), 32'd0);
    wait_idle(1500);

    // Reset in the middle of a frame.
    tx_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      expect_frame(3'b000, b);
      write_byte(b);
    end
    tx_hold = 1'b0;
    tick();
    wait_tx_latched(20);
    tick(); tick(); tick(); tick();
    check("rst_mid_level3", 32'(level), 32'd3);
    check("rst_mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_total -= 4;
    check_reset_values("rst_mid");
    s0 = n_starts;
    repeat (100) tick();
    check("rst_no_start", 32'(n_starts - s0), 32'd0);

    // Loopback with random bytes and a random format per frame.
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      f = 3'($urandom);
      set_cfg(f);
      expect_frame(f, b);
      write_byte(b);
      tick();
      check("loop_ctrl", 32'(tx_ctrl_o), 32'({f, 1'b1}));
      set_cfg(3'($urandom));
      wait_idle(300);
    end

    check("no_start_while_not_ready", 32'(bad_start), 32'd0);
    check("start_width_max", 32'(max_run), 32'd1);
    check("frame_fields_stable", 32'(unstable), 32'd0);
    check("frames_decoded", 32'(rx_frames), 32'(exp_total));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
